// File: rtl/life_step_engine.sv
// One Game-of-Life (B3/S23) generation of an 8x8 board, written back one row per cycle.
// A snapshot taken on start isolates the computation from the board's own updates.
module life_step_engine #(
    parameter int unsigned WRAP  = 0,
    parameter int unsigned GEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      cells_in,
    output logic             busy,
    output logic             write,
    output logic [2:0]       row_select,
    output logic [7:0]       row_val,
    output logic             done,
    output logic             stable,
    output logic [6:0]       alive_count,
    output logic [GEN_W-1:0] gen_count
);

    localparam int DIM = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [63:0]        snapshot_q, snapshot_d;
    logic               write_q, write_d;
    logic [2:0]         row_select_q, row_select_d;
    logic [7:0]         row_val_q, row_val_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               stable_q, stable_d;
    logic [6:0]         alive_q, alive_d;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic [6:0]         sum_q, sum_d;
    logic               mismatch_q, mismatch_d;

    logic [63:0]        calc_board;
    logic [2:0]         calc_row;
    logic [7:0]         new_row;
    logic [7:0]         old_row;

    // Next-generation value of row r; neighbours off the grid are dead unless WRAP.
    function automatic logic [7:0] next_row(input logic [63:0] b, input logic [2:0] r);
        logic [7:0] res;
        logic [3:0] n;
        int         rr;
        int         cc;
        res = '0;
        for (int c = 0; c < DIM; c++) begin
            n = '0;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (dr != 0 || dc != 0) begin
                        rr = int'(r) + dr;
                        cc = c + dc;
                        if (WRAP != 0) begin
                            rr = rr & (DIM - 1);
                            cc = cc & (DIM - 1);
                        end
                        if (rr >= 0 && rr < DIM && cc >= 0 && cc < DIM) begin
                            n = n + 4'(b[{3'(rr), 3'(cc)}]);
                        end
                    end
                end
            end
            res[3'(c)] = (n == 4'd3) || (b[{r, 3'(c)}] && n == 4'd2);
        end
        return res;
    endfunction

    function automatic logic [6:0] popcount8(input logic [7:0] v);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < DIM; i++) begin
            p = p + 7'(v[i]);
        end
        return p;
    endfunction

    // Row 0 is computed on the start edge straight from cells_in, the rest from the snapshot.
    assign calc_board = (state_q == IDLE) ? cells_in : snapshot_q;
    assign calc_row   = (state_q == IDLE) ? 3'd0 : row_select_q + 3'd1;
    assign new_row    = next_row(calc_board, calc_row);
    assign old_row    = calc_board[{calc_row, 3'b000} +: 8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (row_select_q == 3'd7) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        snapshot_d   = snapshot_q;
        write_d      = 1'b0;
        row_select_d = row_select_q;
        row_val_d    = row_val_q;
        busy_d       = (state_d != IDLE);
        done_d       = 1'b0;
        stable_d     = stable_q;
        alive_d      = alive_q;
        gen_d        = gen_q;
        sum_d        = sum_q;
        mismatch_d   = mismatch_q;
        if (state_d == CALC) begin
            write_d      = 1'b1;
            row_select_d = calc_row;
            row_val_d    = new_row;
            if (state_q == IDLE) begin
                snapshot_d = cells_in;
                sum_d      = popcount8(new_row);
                mismatch_d = (new_row != old_row);
            end else begin
                sum_d      = sum_q + popcount8(new_row);
                mismatch_d = mismatch_q | (new_row != old_row);
            end
        end
        if (state_d == DONE) begin
            done_d   = 1'b1;
            alive_d  = sum_q;
            stable_d = ~mismatch_q;
            gen_d    = gen_q + GEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot_q   <= '0;
            write_q      <= 1'b0;
            row_select_q <= '0;
            row_val_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stable_q     <= 1'b0;
            alive_q      <= '0;
            gen_q        <= '0;
            sum_q        <= '0;
            mismatch_q   <= 1'b0;
        end else begin
            snapshot_q   <= snapshot_d;
            write_q      <= write_d;
            row_select_q <= row_select_d;
            row_val_q    <= row_val_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            stable_q     <= stable_d;
            alive_q      <= alive_d;
            gen_q        <= gen_d;
            sum_q        <= sum_d;
            mismatch_q   <= mismatch_d;
        end
    end

    assign busy        = busy_q;
    assign write       = write_q;
    assign row_select  = row_select_q;
    assign row_val     = row_val_q;
    assign done        = done_q;
    assign stable      = stable_q;
    assign alive_count = alive_q;
    assign gen_count   = gen_q;

endmodule

// File: doc/life_step_engine.md
Name: life_step_engine

Overview:
Computes one Game-of-Life generation (rule B3/S23) of the 8x8 board. It reads the board's 64-bit cell vector and writes the next generation back one row per cycle over the board's row-load interface (write / row_select / row_val). It sits downstream of the board register and feeds the board's load port, alternating with the ring pattern writer. A start/busy/done handshake lets the top-level controller single-step or free-run the automaton.

Parameters:
WRAP, 0, 0 = cells outside the 8x8 grid are dead; 1 = toroidal edges (row/col indices modulo 8)
GEN_W, 16, width of the generation counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request one generation step; sampled only in IDLE
cells_in  input  64  current board; row r = cells_in[8r+7:8r], bit c of a row = column c
busy  output  1  high whenever the FSM is not in IDLE
write  output  1  row-load strobe to the board
row_select  output  3  row index being written
row_val  output  8  next-generation value for row_select
done  output  1  one-cycle pulse when a generation has been fully written
stable  output  1  valid with done and held afterwards: new generation equals the snapshot
alive_count  output  7  population of the new generation (0..64), updated with done, held afterwards
gen_count  output  GEN_W  number of completed generations; wraps modulo 2^GEN_W

Behaviour:
- Reset (async, immediate) forces state IDLE, and the following outputs/registers to 0: write, row_select, row_val, busy, done, stable, alive_count, gen_count, snapshot.
- FSM states: IDLE, CALC, DONE.
- IDLE: if start=1 at edge k, snapshot <= cells_in, row counter <= 0, go to CALC. Otherwise stay.
- CALC: occupies the cycles after edges k..k+7 (8 cycles). Its outputs are all registered:
  - write=1; row_select = 0,1,...,7 in order.
  - row_val = next-gen row computed from the snapshot only. Later changes to cells_in, including the board's own updates, have no effect.
  - Per cell: count the 8 neighbours. Result is 1 if count==3, or if the cell is alive and count==2; else 0.
  - Neighbour indexing: with WRAP=0, out-of-range neighbours are 0; with WRAP=1, indices wrap 3-bit (row -1 -> 7, col 8 -> 0).
- Accumulators during CALC:
  - popcount of each row_val accumulates into a 7-bit running sum (max 64, no overflow).
  - a mismatch flag ORs (row_val != snapshot row).
- After the row-7 cycle the FSM goes to DONE for one cycle:
  - write=0, done=1.
  - alive_count <= sum; stable <= ~mismatch; gen_count <= gen_count+1.
  - Next state is IDLE.
- busy=1 in CALC and DONE. start is ignored while busy; there is no queuing. A new start is accepted at the earliest on the edge that ends DONE+1, i.e. back in IDLE.
- Latency: start edge k -> first write cycle k+1 -> done pulse in cycle k+9. Minimum period between accepted starts is 10 cycles.
- Reset mid-operation: write drops asynchronously and no done pulse occurs. The board keeps any rows already written (partial generation); gen_count, alive_count and stable read 0.
- start and reset asserted together: reset wins.
- The engine never drives write outside CALC. Arbitration with other board writers is the top level's job, gated by busy.

Test Plan:
- Blinker, WRAP=0: row3=8'b00011100, all other rows 0, pulse start. Required: rows 2,3,4 written 8'b00001000, all others 8'h00. done at start+9; alive_count=3, stable=0, gen_count=1.
- Block, still life: row0=row1=8'b00000011, others 0. Required: identical rows written, alive_count=4, stable=1. A second step gives gen_count=2, stable=1.
- Edge wrap: row0=8'b10000011, others 0. With WRAP=1: rows 7,0,1 = 8'b00000001, alive_count=3. With WRAP=0: all rows 0, alive_count=0.
- Full board, WRAP=0: cells_in=64'hFFFF_FFFF_FFFF_FFFF. Required: rows 0 and 7 = 8'b10000001, rows 1..6 = 0, alive_count=4, stable=0.
- Snapshot isolation and start while busy: during CALC, change cells_in to all-ones and hold start=1. Required: output still matches the blinker result. Exactly one done pulse in 9 cycles; a new run starts only after busy falls.
- Reset mid-run: assert reset while row_select=4. Required: write=0 in the same cycle, no done, gen_count=0. After release, IDLE with busy=0.
